dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter N, default 64, data and address width in bits.
REQ-002 Parameter DEPTH, default 64, number of N-bit words stored.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 DM_addr  input  N  byte address from the datapath.
REQ-007 DM_writeData  input  N  store data.
REQ-008 DM_writeEnable  input  1  store request.
REQ-009 DM_readEnable  input  1  load request.
REQ-010 DM_readData  output  N  load result; valid only while DM_ready=1, else 0.
REQ-011 DM_ready  output  1  one-cycle response strobe ending a transaction.
REQ-012 DM_error  output  1  transaction faulted; valid only while DM_ready=1, else 0.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, when DM_readEnable or DM_writeEnable is 1, the block SHALL latch address, write data and operation, load cnt=LATENCY-1 and go to WAIT.
REQ-015 In WAIT it SHALL decrement cnt each cycle and go to RESP on the edge where cnt==0; DM_ready is high after edge E0+LATENCY, where E0 is the accepting edge.
REQ-016 On the edge entering RESP, a legal write SHALL commit mem[DM_addr[log2(DEPTH)+2:3]], and a legal read SHALL register the addressed word into DM_readData.
REQ-017 RESP SHALL last exactly one cycle with DM_ready=1, then return to IDLE; a new request is accepted only in IDLE.
REQ-018 Request inputs SHALL be ignored in WAIT and RESP; the latched copies govern the transaction.
REQ-019 Error conditions: DM_addr[2:0]!=0 (misaligned), DM_addr >= DEPTH*8 (out of range), or both enables high together.
REQ-020 On error the block SHALL perform no write, drive DM_readData=0 and assert DM_error=1 with DM_ready.
REQ-021 A read issued after a write's DM_ready SHALL return the newly written value (no stale data).
REQ-022 cnt SHALL be 4 bits and SHALL never wrap below 0.

Reset
REQ-023 When reset=0, the block SHALL go to IDLE immediately, set cnt=0, set DM_ready, DM_error and DM_readData to 0, and clear all DEPTH words to 0.
REQ-024 A transaction in flight when reset asserts SHALL be aborted with no write committed and no DM_ready produced.
REQ-025 The first request SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-026 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the default DEPTH and LATENCY, and the width constant for cnt.
REQ-027 One sub-module, dmem_array, SHALL hold the storage: write port, registered read, clear on reset.
REQ-028 The FSM, latency counter and error decode SHALL reside in dmem_responder.

Verification
REQ-029 LATENCY=2: write addr 0x10, data 0xDEADBEEF; then read 0x10 -> DM_ready high after E0+2 both times, read returns 0xDEADBEEF, DM_error=0.
REQ-030 Write addr 0x0B -> DM_error=1 with DM_ready; a read of 0x08 afterwards returns 0.
REQ-031 Read addr 0x200 (DEPTH=64) -> DM_error=1 and DM_readData=0.
REQ-032 Both enables high at addr 0x00 -> DM_error=1; mem[0] is unchanged.
REQ-033 Assert reset in WAIT of a write to 0x18 -> no DM_ready; after release, a read of 0x18 returns 0.
REQ-034 Change DM_addr from 0x20 to 0x28 during WAIT of a read -> the response carries mem[4] (the address latched at 0x20), not mem[5].

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 2;
  localparam int CNT_W           = 4;

  // Transaction phases: idle, counting down latency, one-cycle response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: one write port, registered read, cleared on reset.
// The read register holds data only for the cycle after a read strobe and
// returns to zero otherwise, so downstream sees zero outside a response.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // Storage update: clear every word on reset, otherwise commit strobed writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read: capture the addressed word on a read strobe, else zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder.
// Handshake: a request (DM_readEnable or DM_writeEnable high) is accepted on
// any rising edge while the FSM is IDLE; request inputs are ignored at all
// other times. Exactly LATENCY edges after acceptance DM_ready pulses high for
// one cycle, and DM_error/DM_readData are meaningful only during that pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N       = 64,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_ready,
  output logic         DM_error,
  output state_t       fsm_state
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [N:0]        LIMIT    = (N+1)'(DEPTH * 8);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             finish;

  logic [AW-1:0]    idx_q;
  logic [N-1:0]     wdata_q;
  op_t              op_q;
  logic             err_q;

  logic             req;
  logic             req_err;
  logic             mem_we;
  logic             mem_re;
  logic [N-1:0]     rdata;

  // Error decode on the live request: misaligned, out of range, or both enables.
  always_comb begin
    req     = DM_readEnable | DM_writeEnable;
    req_err = (DM_addr[2:0] != 3'b000)
            | ({1'b0, DM_addr} >= LIMIT)
            | (DM_readEnable & DM_writeEnable);
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter stops at zero rather than wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the request on acceptance; these copies govern the transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= DM_addr[AW+2:3];
      wdata_q <= DM_writeData;
      op_q    <= DM_writeEnable ? OP_WRITE : OP_READ;
      err_q   <= req_err;
    end
  end

  // Memory strobes fire on the edge that enters RESP, only for legal requests.
  always_comb begin
    mem_we = finish & (op_q == OP_WRITE) & ~err_q;
    mem_re = finish & (op_q == OP_READ)  & ~err_q;
  end

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Response outputs; read data is already zero outside a legal read response.
  always_comb begin
    DM_ready    = (state_q == RESP);
    DM_error    = DM_ready & err_q;
    DM_readData = rdata;
    fsm_state   = state_q;
  end

endmodule
